// File: rtl/scene_rom_arbiter.sv
// Round-robin arbiter sharing the dual-port scene ROM among NREQ ray-pipeline requesters.
// Each accepted beat reads A on port a and B on port b; a tag pipeline routes the data back.
module scene_rom_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 18,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*AW-1:0] req_addr_a,
  input  logic [NREQ*AW-1:0] req_addr_b,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_q_a,
  output logic [DW-1:0]      rsp_q_b,
  output logic [AW-1:0]      rom_addr_a,
  output logic [AW-1:0]      rom_addr_b,
  output logic               rom_rden_a,
  output logic               rom_rden_b,
  input  logic [DW-1:0]      rom_q_a,
  input  logic [DW-1:0]      rom_q_b,
  output logic               busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]  last_q, owner_q;
  logic            lock_vld_q;
  logic [AW-1:0]   addr_a_q, addr_b_q;
  logic            rden_q;
  logic [RD_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]  tag_id_q [RD_LAT];
  logic [NREQ-1:0] rsp_vld_q;

  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  cand;
  logic [AW-1:0]   addr_a_d, addr_b_d;

  // Arbitration: a held lock pins eligibility to the owner, otherwise search from last+1.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    if (lock_vld_q) begin
      grant_vld = req_valid[owner_q];
      grant_id  = owner_q;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IDW'((int'(last_q) + k) % NREQ);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_id  = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant_vld && (grant_id == IDW'(i));
    end
  end

  assign addr_a_d = req_addr_a[grant_id*AW +: AW];
  assign addr_b_d = req_addr_b[grant_id*AW +: AW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= IDW'(NREQ - 1);
      owner_q    <= '0;
      lock_vld_q <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      rden_q     <= 1'b0;
      tag_vld_q  <= '0;
      for (int j = 0; j < RD_LAT; j++) begin
        tag_id_q[j] <= '0;
      end
      rsp_vld_q  <= '0;
    end else begin
      // Stage p0: issue the granted beat to both ROM ports and record its tag.
      rden_q <= grant_vld;
      if (grant_vld) begin
        addr_a_q   <= addr_a_d;
        addr_b_q   <= addr_b_d;
        last_q     <= grant_id;
        owner_q    <= grant_id;
        lock_vld_q <= req_lock[grant_id];
      end
      tag_vld_q[0] <= grant_vld;
      tag_id_q[0]  <= grant_id;
      // Stages p1..: tags age in step with the ROM read latency.
      for (int j = 1; j < RD_LAT; j++) begin
        tag_vld_q[j] <= tag_vld_q[j-1];
        tag_id_q[j]  <= tag_id_q[j-1];
      end
      // Response stage: decode the oldest tag while the ROM data is on the bus.
      rsp_vld_q <= '0;
      if (tag_vld_q[RD_LAT-1]) begin
        rsp_vld_q[tag_id_q[RD_LAT-1]] <= 1'b1;
      end
    end
  end

  assign rom_addr_a = addr_a_q;
  assign rom_addr_b = addr_b_q;
  assign rom_rden_a = rden_q;
  assign rom_rden_b = rden_q;
  assign rsp_valid  = rsp_vld_q;
  assign rsp_q_a    = rom_q_a;
  assign rsp_q_b    = rom_q_b;
  assign busy       = lock_vld_q | (|tag_vld_q);

endmodule

// File: tb/tb_scene_rom_arbiter.sv
// Bench for scene_rom_arbiter: RD_LAT=1 and RD_LAT=3 instances share stimulus and are
// compared each cycle against an edge-indexed record of accepted beats.
module tb_scene_rom_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 18;
  localparam int DW   = 32;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [NREQ-1:0]    req_valid, req_lock;
  logic [NREQ*AW-1:0] req_addr_a, req_addr_b;

  logic [NREQ-1:0] ready1, ready3, rspv1, rspv3;
  logic [DW-1:0]   qa1, qb1, qa3, qb3;
  logic [AW-1:0]   ra1, rb1, ra3, rb3;
  logic            rda1, rdb1, rda3, rdb3, busy1, busy3;
  logic [DW-1:0]   romqa1, romqb1, romqa3, romqb3;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'hC0DE0000 ^ {14'h0, a} ^ {a, 14'h0};
  endfunction

  scene_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_ready(ready1),
    .rsp_valid(rspv1), .rsp_q_a(qa1), .rsp_q_b(qb1), .rom_addr_a(ra1), .rom_addr_b(rb1),
    .rom_rden_a(rda1), .rom_rden_b(rdb1), .rom_q_a(romqa1), .rom_q_b(romqb1), .busy(busy1));

  scene_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_ready(ready3),
    .rsp_valid(rspv3), .rsp_q_a(qa3), .rsp_q_b(qb3), .rom_addr_a(ra3), .rom_addr_b(rb3),
    .rom_rden_a(rda3), .rom_rden_b(rdb3), .rom_q_a(romqa3), .rom_q_b(romqb3), .busy(busy3));

  // ROM models with 1 and 3 cycles of read latency.
  logic [DW-1:0] pa1, pb1;
  logic [DW-1:0] pa3 [3];
  logic [DW-1:0] pb3 [3];
  always @(posedge clk) begin
    if (rda1) pa1 <= rom_word(ra1);
    if (rdb1) pb1 <= rom_word(rb1);
    if (rda3) pa3[0] <= rom_word(ra3);
    if (rdb3) pb3[0] <= rom_word(rb3);
    pa3[1] <= pa3[0]; pa3[2] <= pa3[1];
    pb3[1] <= pb3[0]; pb3[2] <= pb3[1];
  end
  assign romqa1 = pa1;
  assign romqb1 = pb1;
  assign romqa3 = pa3[2];
  assign romqb3 = pb3[2];

  int checks = 0;
  int errors = 0;

  // Reference state: edge-indexed log of accepted beats plus lock/pointer state.
  int          n;
  bit          acc_v  [HMAX];
  int          acc_id [HMAX];
  logic [AW-1:0] acc_a [HMAX];
  logic [AW-1:0] acc_b [HMAX];
  int          m_last, m_owner;
  bit          m_lock;
  logic [AW-1:0] m_addr_a, m_addr_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    n = 0;
    for (int i = 0; i < HMAX; i++) begin
      acc_v[i] = 1'b0; acc_id[i] = 0; acc_a[i] = '0; acc_b[i] = '0;
    end
    m_last = NREQ - 1; m_owner = 0; m_lock = 1'b0;
    m_addr_a = '0; m_addr_b = '0;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a, input logic [AW-1:0] b);
    req_addr_a[i*AW +: AW] = a;
    req_addr_b[i*AW +: AW] = b;
  endtask

  task automatic check_dut(input int L, input string nm, input logic [NREQ-1:0] rv,
                           input logic [DW-1:0] qa, input logic [DW-1:0] qb,
                           input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                           input logic rda, input logic rdb, input logic bz);
    logic [NREQ-1:0] erv;
    bit ebusy;
    int k;
    erv = '0;
    k = n - L;
    if (k >= 1 && acc_v[k]) erv[acc_id[k]] = 1'b1;
    chk({nm, "_rsp_valid"}, 64'(rv), 64'(erv));
    if (k >= 1 && acc_v[k]) begin
      chk({nm, "_rsp_q_a"}, 64'(qa), 64'(rom_word(acc_a[k])));
      chk({nm, "_rsp_q_b"}, 64'(qb), 64'(rom_word(acc_b[k])));
    end
    chk({nm, "_rom_rden_a"}, 64'(rda), 64'(acc_v[n]));
    chk({nm, "_rom_rden_b"}, 64'(rdb), 64'(acc_v[n]));
    chk({nm, "_rom_addr_a"}, 64'(ra), 64'(m_addr_a));
    chk({nm, "_rom_addr_b"}, 64'(rb), 64'(m_addr_b));
    ebusy = m_lock;
    for (int j = n - L + 1; j <= n; j++) begin
      if (j >= 1 && acc_v[j]) ebusy = 1'b1;
    end
    chk({nm, "_busy"}, 64'(bz), 64'(ebusy));
  endtask

  // One clock: drive requests, check all outputs, then log the accept at the edge.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] lk, input int exp_rdy);
    int g, best, d;
    bit gv;
    logic [NREQ-1:0] erdy;
    req_valid = v;
    req_lock  = lk;
    #1;
    gv = 1'b0; g = 0; best = NREQ;
    if (m_lock) begin
      gv = v[m_owner];
      g  = m_owner;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        d = (i - m_last - 1 + 2*NREQ) % NREQ;
        if (v[i] && d < best) begin
          best = d; g = i; gv = 1'b1;
        end
      end
    end
    erdy = '0;
    if (gv) erdy[g] = 1'b1;
    chk("ready_lat1", 64'(ready1), 64'(erdy));
    chk("ready_lat3", 64'(ready3), 64'(erdy));
    if (exp_rdy >= 0) chk("directed_ready", 64'(ready1), 64'(exp_rdy));
    check_dut(1, "lat1", rspv1, qa1, qb1, ra1, rb1, rda1, rdb1, busy1);
    check_dut(3, "lat3", rspv3, qa3, qb3, ra3, rb3, rda3, rdb3, busy3);
    @(posedge clk);
    n++;
    acc_v[n]  = gv;
    acc_id[n] = g;
    acc_a[n]  = req_addr_a[g*AW +: AW];
    acc_b[n]  = req_addr_b[g*AW +: AW];
    if (gv) begin
      m_last = g; m_owner = g; m_lock = lk[g];
      m_addr_a = acc_a[n]; m_addr_b = acc_b[n];
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_rsp_valid1", 64'(rspv1), 64'(0));
    chk("rst_rsp_valid3", 64'(rspv3), 64'(0));
    chk("rst_rden1", 64'({rda1, rdb1}), 64'(0));
    chk("rst_rden3", 64'({rda3, rdb3}), 64'(0));
    chk("rst_busy1", 64'(busy1), 64'(0));
    chk("rst_busy3", 64'(busy3), 64'(0));
    chk("rst_addr1", 64'({ra1, rb1}), 64'(0));
    chk("rst_addr3", 64'({ra3, rb3}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0; req_lock = '0; req_addr_a = '0; req_addr_b = '0;
    model_clear();
    do_reset();

    // Round-robin over all four requesters.
    for (int i = 0; i < NREQ; i++) set_addr(i, AW'(2*i + 2), AW'(2*i + 3));
    for (int c = 0; c < 8; c++) cycle(4'b1111, 4'b0000, 1 << (c % 4));
    repeat (4) cycle(4'b0000, 4'b0000, 0);

    // Requester 1 locks for three beats while 0 and 3 wait.
    cycle(4'b0001, 4'b0000, 4'b0001);
    for (int c = 0; c < 3; c++) begin
      set_addr(1, AW'(32'h100 + c), AW'(32'h103 + c));
      cycle(4'b1011, (c < 2) ? 4'b0010 : 4'b0000, 4'b0010);
    end
    cycle(4'b1001, 4'b0000, 4'b1000);
    cycle(4'b1001, 4'b0000, 4'b0001);
    repeat (4) cycle(4'b0000, 4'b0000, 0);

    // Locked owner 2 bubbles for three cycles, others stay blocked.
    set_addr(2, 18'h2ABCD, 18'h3FFFF);
    cycle(4'b0100, 4'b0100, 4'b0100);
    repeat (3) cycle(4'b1011, 4'b0000, 0);
    cycle(4'b1111, 4'b0100, 4'b0100);
    cycle(4'b1111, 4'b0000, 4'b0100);
    cycle(4'b1111, 4'b0000, 4'b1000);
    repeat (4) cycle(4'b0000, 4'b0000, 0);

    // Single requester streaming, then a quiet period.
    for (int c = 0; c < 6; c++) begin
      set_addr(0, AW'(32'h1000 + 2*c), AW'(32'h2000 + 3*c));
      cycle(4'b0001, 4'b0000, 4'b0001);
    end
    repeat (5) cycle(4'b0000, 4'b0000, 0);

    // Reset with a beat in flight and a lock held.
    cycle(4'b0100, 4'b0100, 4'b0100);
    do_reset();
    cycle(4'b1111, 4'b0000, 4'b0001);
    repeat (5) cycle(4'b0000, 4'b0000, 0);

    // Random traffic against the reference.
    for (int c = 0; c < 300; c++) begin
      logic [NREQ-1:0] v, lk;
      for (int i = 0; i < NREQ; i++) begin
        set_addr(i, AW'($urandom), AW'($urandom));
        lk[i] = ($urandom_range(0, 3) == 0);
      end
      v = NREQ'($urandom_range(0, 15));
      cycle(v, lk, -1);
    end
    repeat (5) cycle(4'b0000, 4'b0000, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scene_rom_arbiter.md
Name: scene_rom_arbiter

Overview:
Shares the dual-port scene ROM (BVH nodes, vertices, normals, faces; 32-bit words, 18-bit word address) among up to NREQ ray-pipeline requesters, such as traversal FSMs, the bbox intersector and the triangle fetcher.
- Each accepted request is one "beat": a paired read of address A on ROM port a and address B on ROM port b.
- Arbitration is round-robin, with an optional lock so one requester can complete a multi-beat sequence uninterrupted (e.g. 3 bbox min/max pairs, or header reads).
- Read data is returned to the originating requester after the fixed ROM latency.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 18, ROM word address width
- DW, 32, ROM data width
- RD_LAT, 1, cycles from rom_addr_* valid to rom_q_* valid (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester beat request
- req_lock  in  NREQ  keep grant after this beat
- req_addr_a  in  NREQ*AW  port-a address; requester i uses bits [i*AW +: AW]
- req_addr_b  in  NREQ*AW  port-b address; same packing as req_addr_a
- req_ready  out  NREQ  beat accepted this cycle; combinational, at most one bit high
- rsp_valid  out  NREQ  one-hot, response data valid for requester i
- rsp_q_a  out  DW  port-a read data, shared by all requesters
- rsp_q_b  out  DW  port-b read data, shared by all requesters
- rom_addr_a  out  AW  ROM port-a address, registered
- rom_addr_b  out  AW  ROM port-b address, registered
- rom_rden_a  out  1  ROM port-a read enable, registered
- rom_rden_b  out  1  ROM port-b read enable, registered
- rom_q_a  in  DW  ROM port-a data
- rom_q_b  in  DW  ROM port-b data
- busy  out  1  lock held or any beat in flight

Behaviour:
Reset values:
- rom_addr_a/b = 0, rom_rden_a/b = 0, rsp_valid = 0, busy = 0.
- Tag pipeline cleared, lock cleared.
- Round-robin pointer last = NREQ-1, so requester 0 has top priority after reset.

Arbitration (combinational, per cycle):
- Unlocked: grant the first i with req_valid[i]=1, searching (last+1) mod NREQ upward with wrap. req_ready[grant]=1; all other ready bits are 0.
- Locked (owner o): only requester o is eligible. req_ready[o] = req_valid[o]; all others 0. No requester is ever granted twice in the same cycle.

Accept:
- A beat is accepted when valid & ready are high at a rising edge.
- At that edge: rom_addr_a/b <= requester's addresses; rom_rden_a/b <= 1; last <= grant; lock_valid <= req_lock[grant]; lock owner <= grant.
- An accepted beat with req_lock=0 from the owner releases the lock at that edge.

Idle behaviour:
- With no accept: rom_rden_a/b <= 0, rom_addr_a/b hold their values.
- A locked owner with req_valid low keeps the lock. Bubbles are allowed; others stay blocked.

Response:
- A tag pipeline of depth RD_LAT carries {valid, id}.
- Beat accepted at edge k: rsp_valid[id] is high for exactly the cycle following edge k+RD_LAT.
- rsp_q_a/b = rom_q_a/b, passed through combinationally.
- Throughput: 1 beat/cycle, back-to-back with no bubble, including across requester switches.
- Responses have no backpressure; requesters must sink them.

Lock rules:
- Lock is taken only on an accepted beat.
- Round-robin pointer still advances to the owner on each beat.
- After release, search resumes at owner+1.

busy:
- busy = lock_valid | any tag-pipeline valid.

Reset mid-operation:
- All in-flight tags are dropped; no rsp_valid after reset deassertion for beats accepted before reset.
- Lock is released.

Out-of-range:
- Upper address bits beyond AW are not present. Addresses are passed through unmodified with no wrap logic.

Test Plan:
1. After reset, req_valid=4'b1111 held with lock=0 for 8 cycles -> grant order 0,1,2,3,0,1,2,3. rsp_valid one-hot in the same order, each RD_LAT cycles after its accept. Data matches ROM words at each requester's addresses (e.g. req2 A=0x00006, B=0x00007 returns q_a=mem[6], q_b=mem[7]).
2. Requester 1 issues 3 beats (A=0x100+c, B=0x103+c, c=0..2) with lock=1,1,0 while req0/req3 are valid -> three consecutive grants to 1, req_ready[0]=req_ready[3]=0 during them. Next grant goes to 3, then 0.
3. Locked owner 2 drops req_valid for 3 cycles mid-sequence -> no grants to others, rom_rden=0 for those cycles, busy=1. Owner resumes and completes; lock released on its lock=0 beat.
4. Single requester streams 6 beats back-to-back -> req_ready high every cycle, 6 consecutive rsp_valid pulses. Repeat with RD_LAT=3: same pulse train shifted by 2 cycles.
5. Assert reset while 1 beat is in flight and a lock is held -> rsp_valid stays 0 after reset, busy=0, rom_rden=0, first grant goes to requester 0.
6. No request for 5 cycles -> rom_rden=0, rom_addr holds the last value, busy drops to 0 RD_LAT cycles after the final accept.
